// File: rtl/llr_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_mem_pkg
// Shared definitions for the LDPC LLR/message RAM controller.
//   state_t  : controller FSM states (arbitration / clear engine)
//   REQ_VN   : requester id of the variable-node side (port 0)
//   REQ_CN   : requester id of the check-node side (port 1)
// The ids double as bit indices into the two-bit request/grant vectors.
// ---------------------------------------------------------------------------
package ldpc_mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic REQ_VN = 1'b0;
  localparam logic REQ_CN = 1'b1;

endpackage

// File: rtl/llr_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// llr_mem_arbiter_if
// Bundle of every non-clock signal around the LLR RAM controller.
//   req0_* / req1_* : valid/ready request channels (we, addr, wdata)
//   rsp0_* / rsp1_* : one-cycle read responses
//   init_*          : clear engine start / busy / done
//   ram_*           : single-port synchronous-read RAM pins
// Modports:
//   slave  : the controller (llr_mem_arbiter)
//   master : the environment (requesters plus the RAM instance)
// ---------------------------------------------------------------------------
interface llr_mem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;

  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  init_start;
  logic                  init_busy;
  logic                  init_done;

  logic                  ram_cs;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  init_start,
    input  ram_data_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output init_busy, init_done,
    output ram_cs, ram_we, ram_address, ram_data_in
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output init_start,
    output ram_data_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  init_busy, init_done,
    input  ram_cs, ram_we, ram_address, ram_data_in
  );

endinterface

// File: rtl/llr_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a one-bit priority pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : request vector, bit k = requester k valid
//   en       : arbitration enable; no grant is issued while low
//   gnt[1:0] : one-hot (or zero) combinational grant
// A lone requester always wins; on contention the requester named by
// prio wins. After any grant prio points at the other requester.
// ---------------------------------------------------------------------------
module rr_arb2
  import ldpc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic prio;

  // Grant decode: only the contention case consults the pointer.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio == REQ_CN) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer moves away from whoever was just served; idle cycles keep it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= REQ_VN;
    end else if (|gnt) begin
      prio <= gnt[REQ_VN] ? REQ_CN : REQ_VN;
    end
  end

endmodule

// File: rtl/llr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// llr_mem_arbiter
// Shares the single-port LLR/message RAM between the variable-node side
// (requester 0) and the check-node side (requester 1), and zero-fills
// the RAM on command before decoding.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : llr_mem_arbiter_if.slave carrying the two request channels,
//          the two read-response channels, the clear engine handshake and
//          the RAM pins (cs/we/address/data_in out, data_out in)
// Parameters: DATA_WIDTH (word width), ADDR_WIDTH, DEPTH (words cleared).
// RAM-side outputs are combinational from state, grant and clr_addr; the
// read-valid flags, init_done, state and clr_addr are registered.
// ---------------------------------------------------------------------------
module llr_mem_arbiter
  import ldpc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                clk,
  input  logic                rst,
  llr_mem_arbiter_if.slave    bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_last;
  logic                  arb_en;
  logic [1:0]            gnt;

  logic                  rsp0_valid_q;
  logic                  rsp1_valid_q;
  logic                  init_done_q;

  logic                  ram_cs_c;
  logic                  ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_address_c;
  logic [DATA_WIDTH-1:0] ram_data_in_c;
  logic                  req0_ready_c;
  logic                  req1_ready_c;
  logic                  init_busy_c;

  assign arb_en   = (state == ST_IDLE);
  assign clr_last = (clr_addr == LAST_ADDR);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.req1_valid, bus.req0_valid}),
    .en  (arb_en),
    .gnt (gnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A start pulse seen during a clear is simply ignored,
  // so the clear always runs its full length.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.init_start) begin
          next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_last) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic. In IDLE the granted request is forwarded straight to the
  // RAM in the same cycle; with no grant the RAM pins are parked at zero.
  // In CLEAR the engine owns the port and both requesters are held off.
  always_comb begin
    ram_cs_c      = 1'b0;
    ram_we_c      = 1'b0;
    ram_address_c = '0;
    ram_data_in_c = '0;
    req0_ready_c  = 1'b0;
    req1_ready_c  = 1'b0;
    init_busy_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready_c = gnt[REQ_VN];
        req1_ready_c = gnt[REQ_CN];
        if (gnt[REQ_VN]) begin
          ram_cs_c      = 1'b1;
          ram_we_c      = bus.req0_we;
          ram_address_c = bus.req0_addr;
          ram_data_in_c = bus.req0_wdata;
        end else if (gnt[REQ_CN]) begin
          ram_cs_c      = 1'b1;
          ram_we_c      = bus.req1_we;
          ram_address_c = bus.req1_addr;
          ram_data_in_c = bus.req1_wdata;
        end
      end
      ST_CLEAR: begin
        init_busy_c   = 1'b1;
        ram_cs_c      = 1'b1;
        ram_we_c      = 1'b1;
        ram_address_c = clr_addr;
        ram_data_in_c = '0;
      end
      default: begin
        init_busy_c = 1'b0;
      end
    endcase
  end

  // Clear counter, read-response flags and the done pulse.
  // The counter sits at zero in IDLE so it is already loaded when a clear
  // begins. A read accepted on the edge that enters CLEAR still raises its
  // response flag, because the flag only looks at the grant, not the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_addr     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      rsp0_valid_q <= gnt[REQ_VN] & ~bus.req0_we;
      rsp1_valid_q <= gnt[REQ_CN] & ~bus.req1_we;
      init_done_q  <= (state == ST_CLEAR) && clr_last;
      if (state == ST_CLEAR) begin
        clr_addr <= clr_addr + ADDR_WIDTH'(1);
      end else begin
        clr_addr <= '0;
      end
    end
  end

  assign bus.req0_ready  = req0_ready_c;
  assign bus.req1_ready  = req1_ready_c;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp0_rdata  = bus.ram_data_out;
  assign bus.rsp1_rdata  = bus.ram_data_out;
  assign bus.init_busy   = init_busy_c;
  assign bus.init_done   = init_done_q;
  assign bus.ram_cs      = ram_cs_c;
  assign bus.ram_we      = ram_we_c;
  assign bus.ram_address = ram_address_c;
  assign bus.ram_data_in = ram_data_in_c;

endmodule

// File: tb/tb_llr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_llr_mem_arbiter
// Directed bench for llr_mem_arbiter with a behavioural single-port,
// synchronous-read RAM attached to the RAM pins. Inputs change on the
// falling edge; outputs are sampled just before the rising edge
// (combinational) or 1 time unit after it (registered).
// ---------------------------------------------------------------------------
module tb_llr_mem_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  llr_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  llr_mem_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on cs&we, registered read on cs&!we.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;

  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) begin
        mem[bus.ram_address] <= bus.ram_data_in;
      end else begin
        ram_q <= mem[bus.ram_address];
      end
    end
  end

  assign bus.ram_data_out = ram_q;

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_we    = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_wdata = '0;
    bus.req1_valid = 1'b0;
    bus.req1_we    = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_wdata = '0;
    bus.init_start = 1'b0;
  endtask

  // Single uncontended write from one port while the controller is idle.
  task automatic do_write(input bit port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    if (!port) begin
      bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = a; bus.req1_wdata = d;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    outs = {bus.rsp0_valid, bus.rsp1_valid, bus.init_busy, bus.init_done,
            bus.ram_cs, bus.ram_we, bus.req0_ready, bus.req1_ready};
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000000", outs);
    end
    checks++;
    if (bus.ram_address !== 8'h00 || bus.ram_data_in !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ram_bus: got addr %h data %h expected 00 00",
               bus.ram_address, bus.ram_data_in);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clear();
    int n;
    int bad;
    int nonzero;
    do_write(1'b0, 8'h7F, 8'hFF);
    @(negedge clk);
    bus.init_start = 1'b1;
    #1;
    checks++;
    if (bus.init_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_busy_before: got %b expected 0", bus.init_busy);
    end
    @(negedge clk);
    bus.init_start = 1'b0;
    n = 0;
    bad = 0;
    while (bus.init_busy === 1'b1 && n < 400) begin
      if (bus.ram_cs !== 1'b1 || bus.ram_we !== 1'b1 ||
          bus.ram_address !== AW'(n) || bus.ram_data_in !== 8'h00) begin
        bad++;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("[TB] FAIL clear_length: got %0d cycles expected %0d", n, DEPTH);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL clear_ram_drive: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (bus.init_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_done_pulse: got %b expected 1", bus.init_done);
    end
    @(negedge clk);
    checks++;
    if (bus.init_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_done_width: got %b expected 0", bus.init_done);
    end
    nonzero = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== 8'h00) nonzero++;
    end
    checks++;
    if (nonzero !== 0) begin
      errors++;
      $display("[TB] FAIL clear_contents: got %0d nonzero words expected 0", nonzero);
    end
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h7F;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_read_ready: got %b expected 1", bus.req0_ready);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clear_read_7f: got valid %b data %h expected 1 00",
               bus.rsp0_valid, bus.rsp0_rdata);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 8'h10; bus.req0_wdata = 8'h5A;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.ram_cs, bus.ram_we} !== 4'b1011 ||
        bus.ram_address !== 8'h10 || bus.ram_data_in !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL single_write_drive: got rdy %b%b cs %b we %b addr %h data %h expected 10 1 1 10 5a",
               bus.req0_ready, bus.req1_ready, bus.ram_cs, bus.ram_we, bus.ram_address, bus.ram_data_in);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (bus.rsp0_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_write_no_rsp: got %b expected 0", bus.rsp0_valid);
    end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h10;
    #1;
    checks++;
    if (bus.ram_cs !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_read_drive: got cs %b we %b expected 1 0", bus.ram_cs, bus.ram_we);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 8'h5A || bus.rsp1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_read_rsp: got v0 %b data %h v1 %b expected 1 5a 0",
               bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rsp0_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_rsp_width: got %b expected 0", bus.rsp0_valid);
    end
  endtask

  task automatic test_contention();
    bit exp;
    do_write(1'b1, 8'h20, 8'h33);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h10;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2) == 1;
      #1;
      checks++;
      if (bus.req0_ready !== !exp || bus.req1_ready !== exp ||
          bus.ram_address !== (exp ? 8'h20 : 8'h10)) begin
        errors++;
        $display("[TB] FAIL contention_grant_%0d: got rdy0 %b rdy1 %b addr %h expected winner %0d",
                 i, bus.req0_ready, bus.req1_ready, bus.ram_address, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (!exp) begin
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_rdata !== 8'h5A) begin
          errors++;
          $display("[TB] FAIL contention_rsp_%0d: got v0 %b v1 %b data %h expected 1 0 5a",
                   i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata);
        end
      end else begin
        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_rdata !== 8'h33) begin
          errors++;
          $display("[TB] FAIL contention_rsp_%0d: got v0 %b v1 %b data %h expected 0 1 33",
                   i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_rdata);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_init_with_request();
    int n;
    int bad;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h10;
    bus.init_start = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_req_accept: got %b expected 1", bus.req0_ready);
    end
    @(posedge clk);
    #1;
    bus.init_start = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 8'h20;
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 8'h5A || bus.init_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_pending_rsp: got v0 %b data %h busy %b expected 1 5a 1",
               bus.rsp0_valid, bus.rsp0_rdata, bus.init_busy);
    end
    @(negedge clk);
    n = 0;
    bad = 0;
    while (bus.init_busy === 1'b1 && n < 400) begin
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) bad++;
      bus.init_start = (n == 100);
      n++;
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("[TB] FAIL init_restart_ignored: got %0d cycles expected %0d", n, DEPTH);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL init_ready_blocked: got %0d ready cycles expected 0", bad);
    end
    checks++;
    if (bus.init_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_done_second: got %b expected 1", bus.init_done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.init_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL init_no_rerun: got %b expected 0", bus.init_busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit done_seen;
    logic [DW-1:0] d60;
    logic [DW-1:0] d10;
    do_write(1'b0, 8'd60, 8'hAA);
    do_write(1'b0, 8'd10, 8'hAA);
    @(negedge clk);
    bus.init_start = 1'b1;
    @(negedge clk);
    bus.init_start = 1'b0;
    n = 0;
    while (bus.init_busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 50 || bus.init_busy !== 1'b1 || bus.ram_address !== 8'd50) begin
      errors++;
      $display("[TB] FAIL abort_setup: got n %0d busy %b addr %0d expected 50 1 50",
               n, bus.init_busy, bus.ram_address);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.init_busy, bus.init_done, bus.ram_cs,
         bus.ram_we, bus.ram_address, bus.ram_data_in} !== 22'h0) begin
      errors++;
      $display("[TB] FAIL abort_async_outputs: got %b expected all zero",
               {bus.rsp0_valid, bus.rsp1_valid, bus.init_busy, bus.init_done, bus.ram_cs,
                bus.ram_we, bus.ram_address, bus.ram_data_in});
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.init_done !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %b expected 0", done_seen);
    end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'd60;
    @(posedge clk);
    #1;
    d60 = bus.rsp0_rdata;
    bus.req0_addr = 8'd10;
    @(posedge clk);
    #1;
    d10 = bus.rsp0_rdata;
    idle_inputs();
    checks++;
    if (d60 !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL abort_addr60_kept: got %h expected aa", d60);
    end
    checks++;
    if (d10 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL abort_addr10_cleared: got %h expected 00", d10);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    for (int i = 1; i <= 4; i++) begin
      do_write(1'b1, AW'(i), DW'(8'h11 * i));
    end
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = AW'(i);
      exp = DW'(8'h11 * i);
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", i, bus.req1_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_rdata !== exp || bus.rsp0_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_rsp_%0d: got v1 %b data %h v0 %b expected 1 %h 0",
                 i, bus.rsp1_valid, bus.rsp1_rdata, bus.rsp0_valid, exp);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (bus.rsp1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_tail: got %b expected 0", bus.rsp1_valid);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_single();
    test_contention();
    test_init_with_request();
    test_reset_mid_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
